// File: rtl/key_alu.sv
// Three debounced pushbuttons driving a small W-bit ALU: go executes the
// current mode's operation, clr holds the result at zero, mode cycles ADD/SUB/ACC/CNT.
module key_alu #(
    parameter int W   = 8,
    parameter int DEB = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           key_go,
    input  logic           key_clr,
    input  logic           key_mode,
    input  logic [2*W-1:0] sw,
    output logic [2*W-1:0] LEDR,
    output logic [W-1:0]   LEDG,
    output logic           ovf,
    output logic [1:0]     mode
);

    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int K_GO   = 0;
    localparam int K_CLR  = 1;
    localparam int K_MODE = 2;

    localparam logic [1:0] M_ADD = 2'd0;
    localparam logic [1:0] M_SUB = 2'd1;
    localparam logic [1:0] M_ACC = 2'd2;
    localparam logic [1:0] M_CNT = 2'd3;

    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          lvl_q, lvl_d;
    logic [2:0]          pulse_q, pulse_d;
    logic [2:0][CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]        ledg_q, ledg_d;
    logic                ovf_q, ovf_d;
    logic [1:0]          mode_q, mode_d;

    logic [W:0] a_ext, b_ext, add_r, sub_r, acc_r, inc_r;

    // Debounce: the counter only runs while the synchronised sample disagrees
    // with the accepted level; DEB disagreeing samples in a row flip the level.
    always_comb begin
        sync1_d = {key_mode, key_clr, key_go};
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        cnt_d   = '0;
        for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] != lvl_q[k]) begin
                if (cnt_q[k] == CW'(DEB - 1)) begin
                    lvl_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
        pulse_d = lvl_q & ~lvl_d;
    end

    always_comb begin
        a_ext = {1'b0, sw[2*W-1:W]};
        b_ext = {1'b0, sw[W-1:0]};
        add_r = a_ext + b_ext;
        sub_r = a_ext - b_ext;
        acc_r = {1'b0, ledg_q} + a_ext;
        inc_r = {1'b0, ledg_q} + (W+1)'(1);

        ledg_d = ledg_q;
        ovf_d  = ovf_q;
        mode_d = mode_q;
        if (pulse_q[K_MODE]) begin
            mode_d = mode_q + 2'd1;
        end
        // The operation always uses the pre-advance mode_q.
        if (!lvl_q[K_CLR]) begin
            ledg_d = '0;
            ovf_d  = 1'b0;
        end else if (pulse_q[K_GO]) begin
            case (mode_q)
                M_ADD: begin ledg_d = add_r[W-1:0]; ovf_d = add_r[W];          end
                M_SUB: begin ledg_d = sub_r[W-1:0]; ovf_d = sub_r[W];          end
                M_ACC: begin ledg_d = acc_r[W-1:0]; ovf_d = ovf_q | acc_r[W];  end
                M_CNT: begin ledg_d = inc_r[W-1:0]; ovf_d = ovf_q | inc_r[W];  end
                default: begin ledg_d = ledg_q; ovf_d = ovf_q; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            lvl_q   <= '1;
            pulse_q <= '0;
            cnt_q   <= '0;
            ledg_q  <= '0;
            ovf_q   <= 1'b0;
            mode_q  <= M_ADD;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            ledg_q  <= ledg_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
        end
    end

    assign LEDR = sw;
    assign LEDG = ledg_q;
    assign ovf  = ovf_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_key_alu.sv
// Bench for key_alu: fixed vector table, randomized key presses against a
// behavioural model, and directed sequences for sticky flags, clear, glitches and reset.
module tb_key_alu;

    localparam int W   = 8;
    localparam int DEB = 4;
    localparam int MOD = 1 << W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           key_go = 1'b1;
    logic           key_clr = 1'b1;
    logic           key_mode = 1'b1;
    logic [2*W-1:0] sw = 16'hC850;
    logic [2*W-1:0] LEDR;
    logic [W-1:0]   LEDG;
    logic           ovf;
    logic [1:0]     mode;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference state
    int ref_ledg = 0;
    int ref_ovf  = 0;
    int ref_mode = 0;

    key_alu #(.W(W), .DEB(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .key_go(key_go), .key_clr(key_clr),
        .key_mode(key_mode), .sw(sw), .LEDR(LEDR), .LEDG(LEDG), .ovf(ovf), .mode(mode)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0] md;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ledg;
        logic       ov;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds a key low for low_n sampled cycles, then lets it settle released.
    task automatic press(input int key, input int low_n);
        if (key == 0) key_go = 1'b0;
        else if (key == 1) key_clr = 1'b0;
        else key_mode = 1'b0;
        cyc(low_n);
        key_go = 1'b1;
        key_clr = 1'b1;
        key_mode = 1'b1;
        cyc(DEB + 8);
    endtask

    function automatic void model_go(input int a, input int b);
        int s;
        case (ref_mode)
            0: begin s = a + b; ref_ledg = s % MOD; ref_ovf = (s >= MOD); end
            1: begin ref_ovf = (a < b); ref_ledg = (a - b + MOD) % MOD; end
            2: begin s = ref_ledg + a; ref_ovf = ref_ovf | (s >= MOD); ref_ledg = s % MOD; end
            default: begin ref_ovf = ref_ovf | (ref_ledg == MOD - 1); ref_ledg = (ref_ledg + 1) % MOD; end
        endcase
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_ledg"}, 32'(LEDG), 32'(ref_ledg));
        check({tag, "_ovf"},  32'(ovf),  32'(ref_ovf));
        check({tag, "_mode"}, 32'(mode), 32'(ref_mode));
    endtask

    task automatic goto_mode(input int m);
        while (ref_mode != m) begin
            press(2, DEB + 3);
            ref_mode = (ref_mode + 1) % 4;
        end
    endtask

    task automatic go_with(input logic [7:0] a, input logic [7:0] b);
        sw = {a, b};
        press(0, 10);
        model_go(a, b);
    endtask

    initial begin
        int l;
        int r;
        int seen;
        tbl[0] = '{2'd0, 8'hC8, 8'h50, 8'h18, 1'b1};
        tbl[1] = '{2'd0, 8'h01, 8'h02, 8'h03, 1'b0};
        tbl[2] = '{2'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[3] = '{2'd0, 8'h7F, 8'h80, 8'hFF, 1'b0};
        tbl[4] = '{2'd1, 8'h10, 8'h20, 8'hF0, 1'b1};
        tbl[5] = '{2'd1, 8'h30, 8'h20, 8'h10, 1'b0};
        tbl[6] = '{2'd1, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{2'd1, 8'h00, 8'h01, 8'hFF, 1'b1};

        // Reset state
        #1;
        check("rst_ledg", 32'(LEDG), 32'h0);
        check("rst_ovf",  32'(ovf),  32'h0);
        check("rst_mode", 32'(mode), 32'h0);
        check("ledr",     32'(LEDR), 32'hC850);
        cyc(3);
        rst_n = 1'b1;
        cyc(DEB + 4);
        check("idle_ledg", 32'(LEDG), 32'h0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            goto_mode(int'(tbl[i].md));
            go_with(tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_ledg", i), 32'(LEDG), 32'(tbl[i].ledg));
            check($sformatf("tbl%0d_ovf", i),  32'(ovf),  32'(tbl[i].ov));
            check($sformatf("tbl%0d_mode", i), 32'(mode), 32'(tbl[i].md));
            check($sformatf("tbl%0d_ledr", i), 32'(LEDR), 32'({tbl[i].a, tbl[i].b}));
        end

        // sw alone never changes the result
        sw = 16'hA5A5;
        cyc(5);
        check("sw_only", 32'(LEDG), 32'(ref_ledg));

        // Random presses of random length against the model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            sw = 16'($urandom);
            if (r < 6) begin
                l = $urandom_range(1, 8);
                press(0, l);
                if (l >= DEB) model_go(int'(sw[15:8]), int'(sw[7:0]));
            end else if (r < 8) begin
                l = $urandom_range(1, 8);
                press(2, l);
                if (l >= DEB) ref_mode = (ref_mode + 1) % 4;
            end else begin
                press(1, DEB + 2);
                ref_ledg = 0;
                ref_ovf = 0;
            end
            check_model($sformatf("rnd%0d", it));
        end

        // CNT wrap with sticky overflow, seeded through ACC
        goto_mode(2);
        press(1, DEB + 2);
        ref_ledg = 0;
        ref_ovf = 0;
        go_with(8'hFE, 8'h00);
        check("seed_ledg", 32'(LEDG), 32'hFE);
        check("seed_ovf",  32'(ovf),  32'h0);
        goto_mode(3);
        go_with(8'h00, 8'h00);
        check("cnt1_ledg", 32'(LEDG), 32'hFF);
        check("cnt1_ovf",  32'(ovf),  32'h0);
        go_with(8'h00, 8'h00);
        check("cnt2_ledg", 32'(LEDG), 32'h00);
        check("cnt2_ovf",  32'(ovf),  32'h1);
        go_with(8'h00, 8'h00);
        check("cnt3_ledg", 32'(LEDG), 32'h01);
        check("cnt3_ovf",  32'(ovf),  32'h1);

        // Clear held: forced zero, go ignored
        key_clr = 1'b0;
        cyc(DEB + 4);
        check("clr_ledg", 32'(LEDG), 32'h0);
        check("clr_ovf",  32'(ovf),  32'h0);
        key_go = 1'b0;
        cyc(10);
        key_go = 1'b1;
        cyc(DEB + 6);
        check("clr_go_ledg", 32'(LEDG), 32'h0);
        key_clr = 1'b1;
        cyc(DEB + 8);
        check("clr_rel_ledg", 32'(LEDG), 32'h0);
        check("clr_rel_ovf",  32'(ovf),  32'h0);
        ref_ledg = 0;
        ref_ovf = 0;

        // Glitch lengths around DEB, counted in CNT mode
        press(0, 3);
        check("glitch3", 32'(LEDG), 32'h0);
        press(0, DEB - 1);
        check("glitch_deb_m1", 32'(LEDG), 32'h0);
        press(0, DEB);
        check("press_deb", 32'(LEDG), 32'h1);
        press(0, 6);
        check("press6", 32'(LEDG), 32'h2);

        // Simultaneous go and mode in ACC
        goto_mode(0);
        goto_mode(2);
        press(1, DEB + 2);
        go_with(8'h03, 8'h00);
        check("acc_pre", 32'(LEDG), 32'h03);
        sw = 16'h0500;
        key_go = 1'b0;
        key_mode = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (LEDG !== 8'h03 || mode !== 2'd2) seen = 1;
        end
        check("sim_seen", 32'(seen), 32'h1);
        check("sim_ledg", 32'(LEDG), 32'h08);
        check("sim_mode", 32'(mode), 32'h3);
        check("sim_ovf",  32'(ovf),  32'h0);
        key_go = 1'b1;
        key_mode = 1'b1;
        cyc(DEB + 8);

        // Asynchronous reset mid-debounce with key kept low
        sw = 16'h1234;
        key_go = 1'b0;
        cyc(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ledg", 32'(LEDG), 32'h0);
        check("arst_ovf",  32'(ovf),  32'h0);
        check("arst_mode", 32'(mode), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(DEB + 1);
        check("arst_early", 32'(LEDG), 32'h0);
        cyc(4);
        check("arst_late", 32'(LEDG), 32'h46);
        check("arst_late_ovf", 32'(ovf), 32'h0);
        key_go = 1'b1;
        cyc(DEB + 8);
        check("arst_single", 32'(LEDG), 32'h46);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
